// File: rtl/apb_pkg.sv
// Shared definitions for the multi-slave APB master: FSM state encoding and
// default parameter values.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_ADDR_WIDTH     = 32;
  localparam int APB_DATA_WIDTH     = 32;
  localparam int APB_NUM_SLAVES     = 4;
  localparam int APB_SLV_ADDR_BITS  = 12;
  localparam int APB_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decoder: maps an address onto a one-hot slave select
// (each slave owns a 2^SLV_ADDR_BITS byte region) and flags unmapped addresses.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH    = APB_ADDR_WIDTH,
  parameter int NUM_SLAVES    = APB_NUM_SLAVES,
  parameter int SLV_ADDR_BITS = APB_SLV_ADDR_BITS
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  dec_err
);

  logic [ADDR_WIDTH-1:0] idx;

  always_comb begin
    idx     = addr >> SLV_ADDR_BITS;
    dec_err = (idx >= ADDR_WIDTH'(NUM_SLAVES));
    sel     = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel[i] = (idx == ADDR_WIDTH'(i));
    end
  end

endmodule

// File: rtl/apb_master_nslv.sv
// APB master driving NUM_SLAVES PSEL lines with IDLE/SETUP/ACCESS sequencing.
// Optional ACCESS wait-state timeout is enabled by defining APB_TIMEOUT_EN.
module apb_master_nslv
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int NUM_SLAVES     = APB_NUM_SLAVES,
  parameter int SLV_ADDR_BITS  = APB_SLV_ADDR_BITS,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic                             transfer,
  input  logic                             write_read,
  input  logic [ADDR_WIDTH-1:0]            addr_in,
  input  logic [DATA_WIDTH-1:0]            wdata_in,
  input  logic [DATA_WIDTH/8-1:0]          strb_in,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [DATA_WIDTH/8-1:0]          PSTRB,
  output logic [DATA_WIDTH-1:0]            rdata_out,
  output logic                             transfer_done,
  output logic                             error,
  output logic                             busy
);

  apb_state_e state, state_nxt;

  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_err;
  logic                  armed;
  logic                  capture;
  logic                  finish_ok;
  logic                  dec_fail;
  logic                  sel_ready;
  logic                  sel_slverr;
  logic [DATA_WIDTH-1:0] sel_rdata;

  apb_addr_decoder #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .NUM_SLAVES   (NUM_SLAVES),
    .SLV_ADDR_BITS(SLV_ADDR_BITS)
  ) u_dec (
    .addr   (addr_in),
    .sel    (dec_sel),
    .dec_err(dec_err)
  );

  // PSEL is one-hot, so masking with it ignores every unselected slave.
  assign sel_ready  = |(PREADY & PSEL);
  assign sel_slverr = |(PSLVERR & PSEL);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (PSEL[i]) sel_rdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign PENABLE = (state == ACCESS);
  assign busy    = (state != IDLE);

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
`endif

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    finish_ok = 1'b0;
    dec_fail  = 1'b0;
`ifdef APB_TIMEOUT_EN
    tmo_hit   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        // armed holds off any new command until the second edge after reset.
        if (armed && transfer) begin
          if (dec_err) begin
            dec_fail = 1'b1;
          end else begin
            capture   = 1'b1;
            state_nxt = SETUP;
          end
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (sel_ready) begin
          finish_ok = 1'b1;
          if (transfer && !dec_err) begin
            capture   = 1'b1;
            state_nxt = SETUP;
          end else begin
            state_nxt = IDLE;
          end
        end
`ifdef APB_TIMEOUT_EN
        else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state         <= IDLE;
      armed         <= 1'b0;
      PADDR         <= '0;
      PSEL          <= '0;
      PWRITE        <= 1'b0;
      PWDATA        <= '0;
      PSTRB         <= '0;
      rdata_out     <= '0;
      transfer_done <= 1'b0;
      error         <= 1'b0;
    end else begin
      state         <= state_nxt;
      armed         <= 1'b1;
      transfer_done <= 1'b0;
      if (capture) begin
        PADDR  <= addr_in;
        PSEL   <= dec_sel;
        PWRITE <= write_read;
        PWDATA <= wdata_in;
        PSTRB  <= write_read ? strb_in : '0;
      end else if (state_nxt == IDLE) begin
        PSEL <= '0;
      end
      if (finish_ok) begin
        transfer_done <= 1'b1;
        error         <= sel_slverr;
        if (!PWRITE) rdata_out <= sel_rdata;
      end
      if (dec_fail) begin
        transfer_done <= 1'b1;
        error         <= 1'b1;
      end
`ifdef APB_TIMEOUT_EN
      if (tmo_hit) begin
        transfer_done <= 1'b1;
        error         <= 1'b1;
      end
`endif
    end
  end

`ifdef APB_TIMEOUT_EN
  // Counts consecutive stalled ACCESS cycles; cleared whenever ACCESS ends.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tmo_cnt <= '0;
    end else if (state == ACCESS && !sel_ready && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`endif

endmodule
